pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Sequencer/hazard controller for the fetch -> decode -> write_back pipeline. Owns a
//  register scoreboard: stalls decode on RAW/WAW hazards against in-flight writebacks.
//  Squashes fetch after a decode-stage PC redirect and holds fetch during boot.
//  Drains and halts the pipeline on request. Sits beside instruction_decode/write_back
//  in riscv_top and gates the pipeline enables.
// PARAMETERS
//  NREGS        32  number of architectural registers (x0 hard-wired zero)
//  RIDX_W       5   register index width, = $clog2(NREGS)
//  BOOT_CYCLES  2   cycles fetch is held off after reset release (>=1)
//  FLUSH_CYCLES 1   cycles fetch output is squashed after a redirect (>=1)
// PORTS
//  i_clk         in   1       clock, all state on rising edge
//  i_rstn        in   1       asynchronous active-low reset
//  i_id_valid    in   1       decode holds a valid instruction
//  i_id_rs1      in   RIDX_W  source reg 1 index;  i_id_rs1_used in 1  rs1 is read
//  i_id_rs2      in   RIDX_W  source reg 2 index;  i_id_rs2_used in 1  rs2 is read
//  i_id_rd       in   RIDX_W  dest reg index;      i_id_rd_used  in 1  instr writes rd
//  i_id_redirect in   1       decode asserts new PC (update_pc) for this instruction
//  i_wb_valid    in   1       write_back commits a register write this cycle
//  i_wb_rd       in   RIDX_W  register written by write_back
//  i_halt_req    in   1       level request to drain and halt
//  o_issue       out  1       decode instruction accepted this cycle
//  o_id_stall    out  1       decode must hold its instruction
//  o_if_en       out  1       fetch may advance PC / load instruction_reg
//  o_if_flush    out  1       fetched instruction is squashed (treated invalid)
//  o_halted      out  1       pipeline empty and halted
//  o_busy_regs   out  NREGS   scoreboard, bit i = write to xi pending
//  o_sb_err      out  1       sticky: commit to non-pending register seen
//  o_state       out  3       FSM state encoding (debug)
// BEHAVIOUR
//  Reset (async, i_rstn=0): state=BOOT, cnt=BOOT_CYCLES-1, scoreboard=0, o_sb_err=0;
//   all outputs 0 (o_state=BOOT=0).
//  FSM: BOOT=0, RUN=1, FLUSH=2, DRAIN=3, HALT=4.
//   BOOT : o_if_en=0; cnt decrements; cnt==0 -> RUN. If BOOT_CYCLES=1, one BOOT cycle.
//   RUN  : o_if_en = ~o_id_stall. Priority: o_issue&i_id_redirect -> FLUSH
//          (cnt=FLUSH_CYCLES-1); else i_halt_req -> DRAIN; else stay.
//   FLUSH: o_if_flush=1, o_if_en=1, no issue; cnt==0 -> RUN (-> DRAIN if i_halt_req).
//   DRAIN: o_if_en=0, no issue; scoreboard==0 (incl. the cycle's clear) -> HALT.
//   HALT : o_halted=1, o_if_en=0; i_halt_req==0 -> RUN.
//  Hazard (comb): haz = (rs1_used & rs1!=0 & busy[rs1]) | (rs2_used & rs2!=0 & busy[rs2])
//   | (rd_used & rd!=0 & busy[rd]). No bypass: same-cycle commit still stalls.
//  o_issue = state==RUN & i_id_valid & ~haz;  o_id_stall = state==RUN & i_id_valid & haz.
//  Scoreboard update at clock edge: clear bit i_wb_rd if i_wb_valid; then set bit i_id_rd
//   if o_issue & rd_used & rd!=0 (set wins; cannot collide since WAW stalls).
//  Bit 0 never set; commit to x0 ignored, not an error.
//  i_wb_valid to rd!=0 with busy[rd]==0 -> o_sb_err=1 until reset; scoreboard unchanged.
//  i_id_redirect ignored unless o_issue. Inputs in non-RUN states affect only commits.
//  Latency: issue-to-stall-release = commit cycle + 1. Halt: o_halted 1 cycle after
//   scoreboard empties in DRAIN.
//  Reset mid-operation: immediate return to reset values, in-flight bits discarded.
// TESTING
//  Reset release -> o_if_en=0 for 2 cycles, state RUN and o_if_en=1 on 3rd cycle.
//  Issue rd=5, next instr rs1=5 -> o_id_stall=1 until cycle after i_wb_valid,rd=5; then o_issue=1.
//  Issue rd=0 then rs1=0, rs2=0 -> no stall, o_busy_regs stays 0.
//  Issue with i_id_redirect=1 -> o_if_flush=1 for exactly 1 cycle, then RUN, o_if_en=1.
//  x3 pending, i_halt_req=1 -> DRAIN, no issue; commit x3 -> o_halted=1 next cycle; drop req -> RUN.
//  Commit x7 not pending -> o_sb_err=1 sticky; assert i_rstn=0 mid-FLUSH -> all outputs 0 at once.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the fetch -> decode -> write_back pipeline.
// Tracks pending register writes, stalls decode on RAW/WAW hazards, and sequences boot, flush, drain and halt.
module pipeline_ctrl #(
    parameter int NREGS        = 32,
    parameter int RIDX_W       = $clog2(NREGS),
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_id_valid,
    input  logic [RIDX_W-1:0] i_id_rs1,
    input  logic              i_id_rs1_used,
    input  logic [RIDX_W-1:0] i_id_rs2,
    input  logic              i_id_rs2_used,
    input  logic [RIDX_W-1:0] i_id_rd,
    input  logic              i_id_rd_used,
    input  logic              i_id_redirect,
    input  logic              i_wb_valid,
    input  logic [RIDX_W-1:0] i_wb_rd,
    input  logic              i_halt_req,
    output logic              o_issue,
    output logic              o_id_stall,
    output logic              o_if_en,
    output logic              o_if_flush,
    output logic              o_halted,
    output logic [NREGS-1:0]  o_busy_regs,
    output logic              o_sb_err,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam int CNT_MAX = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NREGS-1:0]   busy_q;
    logic [NREGS-1:0]   busy_d;
    logic               err_q;
    logic               err_d;

    logic haz_rs1;
    logic haz_rs2;
    logic haz_rd;
    logic haz;
    logic in_run;
    logic wb_clr;
    logic set_rd;

    // Decode handshake: an instruction with i_id_valid moves on only in a cycle
    // where o_issue is high; while o_id_stall is high decode must hold it unchanged.
    assign in_run  = (state_q == ST_RUN);
    assign haz_rs1 = i_id_rs1_used && (i_id_rs1 != '0) && busy_q[i_id_rs1];
    assign haz_rs2 = i_id_rs2_used && (i_id_rs2 != '0) && busy_q[i_id_rs2];
    assign haz_rd  = i_id_rd_used  && (i_id_rd  != '0) && busy_q[i_id_rd];
    assign haz     = haz_rs1 || haz_rs2 || haz_rd;

    assign o_issue    = in_run && i_id_valid && !haz;
    assign o_id_stall = in_run && i_id_valid && haz;

    assign wb_clr = i_wb_valid && (i_wb_rd != '0);
    assign set_rd = o_issue && i_id_rd_used && (i_id_rd != '0);

    // Commit clears first, issue sets second; WAW stalling keeps them from colliding.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (wb_clr) begin
            if (!busy_q[i_wb_rd]) begin
                err_d = 1'b1;
            end
            busy_d[i_wb_rd] = 1'b0;
        end
        if (set_rd) begin
            busy_d[i_id_rd] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_BOOT;
            cnt_q   <= CNT_W'(BOOT_CYCLES - 1);
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            case (state_q)
                ST_BOOT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (o_issue && i_id_redirect) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                    end else if (i_halt_req) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= i_halt_req ? ST_DRAIN : ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (busy_d == '0) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (!i_halt_req) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    // Fetch only advances in RUN when decode is not stalled, and during FLUSH to refill.
    assign o_if_en     = in_run ? !o_id_stall : (state_q == ST_FLUSH);
    assign o_if_flush  = (state_q == ST_FLUSH);
    assign o_halted    = (state_q == ST_HALT);
    assign o_busy_regs = busy_q;
    assign o_sb_err    = err_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a per-cycle behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pipeline_ctrl;

  localparam int NREGS  = 32;
  localparam int RIDX_W = 5;
  localparam int BOOT_N = 2;
  localparam int FLUSH_N = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              id_valid = 1'b0;
  logic [RIDX_W-1:0] id_rs1 = '0;
  logic              id_rs1_used = 1'b0;
  logic [RIDX_W-1:0] id_rs2 = '0;
  logic              id_rs2_used = 1'b0;
  logic [RIDX_W-1:0] id_rd = '0;
  logic              id_rd_used = 1'b0;
  logic              id_redirect = 1'b0;
  logic              wb_valid = 1'b0;
  logic [RIDX_W-1:0] wb_rd = '0;
  logic              halt_req = 1'b0;

  logic              issue;
  logic              id_stall;
  logic              if_en;
  logic              if_flush;
  logic              halted;
  logic [NREGS-1:0]  busy_regs;
  logic              sb_err;
  logic [2:0]        state;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b1;

  pipeline_ctrl #(
    .NREGS(NREGS), .RIDX_W(RIDX_W), .BOOT_CYCLES(BOOT_N), .FLUSH_CYCLES(FLUSH_N)
  ) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs1_used(id_rs1_used),
    .i_id_rs2(id_rs2), .i_id_rs2_used(id_rs2_used),
    .i_id_rd(id_rd), .i_id_rd_used(id_rd_used),
    .i_id_redirect(id_redirect),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .i_halt_req(halt_req),
    .o_issue(issue), .o_id_stall(id_stall), .o_if_en(if_en), .o_if_flush(if_flush),
    .o_halted(halted), .o_busy_regs(busy_regs), .o_sb_err(sb_err), .o_state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 boot, 1 run, 2 flush, 3 drain, 4 halt; wait_left counts remaining cycles of boot/flush.
  int m_mode = 0;
  int m_wait = BOOT_N;
  bit m_pend[NREGS];
  bit m_err = 1'b0;

  function automatic bit reads_pending(input bit used, input logic [RIDX_W-1:0] r);
    return used && (r != 0) && m_pend[r];
  endfunction

  function automatic bit m_hazard();
    return reads_pending(id_rs1_used, id_rs1) || reads_pending(id_rs2_used, id_rs2) ||
           reads_pending(id_rd_used, id_rd);
  endfunction

  function automatic bit m_issue();
    return (m_mode == 1) && id_valid && !m_hazard();
  endfunction

  function automatic bit m_stall();
    return (m_mode == 1) && id_valid && m_hazard();
  endfunction

  function automatic bit m_if_en();
    if (m_mode == 1) return !m_stall();
    return m_mode == 2;
  endfunction

  function automatic logic [NREGS-1:0] m_busy();
    logic [NREGS-1:0] v = '0;
    for (int i = 0; i < NREGS; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int m_pending_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_wait = BOOT_N;
      m_err  = 1'b0;
      for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
    end else begin
      bit iss;
      iss = m_issue();
      if (wb_valid && wb_rd != 0) begin
        if (!m_pend[wb_rd]) m_err = 1'b1;
        m_pend[wb_rd] = 1'b0;
      end
      if (iss && id_rd_used && id_rd != 0) m_pend[id_rd] = 1'b1;
      case (m_mode)
        0: begin
          m_wait = m_wait - 1;
          if (m_wait == 0) m_mode = 1;
        end
        1: begin
          if (iss && id_redirect) begin
            m_mode = 2;
            m_wait = FLUSH_N;
          end else if (halt_req) begin
            m_mode = 3;
          end
        end
        2: begin
          m_wait = m_wait - 1;
          if (m_wait == 0) m_mode = halt_req ? 3 : 1;
        end
        3: if (m_pending_count() == 0) m_mode = 4;
        4: if (!halt_req) m_mode = 1;
        default: m_mode = 0;
      endcase
    end
  end

  // ---------------- scoreboard / checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_issue", 32'(issue), 32'(m_issue()));
      chk("m_stall", 32'(id_stall), 32'(m_stall()));
      chk("m_if_en", 32'(if_en), 32'(m_if_en()));
      chk("m_if_flush", 32'(if_flush), 32'(m_mode == 2));
      chk("m_halted", 32'(halted), 32'(m_mode == 4));
      chk("m_busy", busy_regs, m_busy());
      chk("m_sb_err", 32'(sb_err), 32'(m_err));
      chk("m_state", 32'(state), 32'(m_mode));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_used = 0; id_redirect = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic drive_id(input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit ud, input bit redir);
    id_valid = 1;
    id_rs1 = RIDX_W'(rs1); id_rs1_used = u1;
    id_rs2 = RIDX_W'(rs2); id_rs2_used = u2;
    id_rd  = RIDX_W'(rd);  id_rd_used  = ud;
    id_redirect = redir;
  endtask

  task automatic commit(input int rd);
    wb_valid = 1;
    wb_rd = RIDX_W'(rd);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    halt_req = 0;
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_if_en", 32'(if_en), 0);
    chk("rst_busy", busy_regs, 0);
    cyc();
    rst_n = 1;

    // boot: fetch held two cycles, RUN on the third
    @(negedge clk); chk("boot1_if_en", 32'(if_en), 0); chk("boot1_state", 32'(state), 0);
    cyc();
    @(negedge clk); chk("boot2_if_en", 32'(if_en), 0);
    cyc();
    @(negedge clk); chk("run_state", 32'(state), 1); chk("run_if_en", 32'(if_en), 1);

    // RAW on x5: stall until the cycle after the commit
    cyc(); drive_id(0, 0, 0, 0, 5, 1, 0);
    @(negedge clk); chk("x5_issue", 32'(issue), 1);
    cyc(); drive_id(5, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("raw_stall", 32'(id_stall), 1); chk("raw_busy", busy_regs, 32'h20);
    chk("raw_if_en", 32'(if_en), 0);
    cyc(); commit(5);
    @(negedge clk); chk("raw_nobypass", 32'(id_stall), 1);
    cyc(); wb_valid = 0;
    @(negedge clk); chk("raw_release", 32'(issue), 1); chk("raw_busy0", busy_regs, 0);

    // x0 never becomes pending
    cyc(); drive_id(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("x0_issue", 32'(issue), 1);
    cyc(); drive_id(0, 1, 0, 1, 0, 0, 0);
    @(negedge clk); chk("x0_nostall", 32'(issue), 1); chk("x0_busy", busy_regs, 0);

    // redirect: one flush cycle, fetch enabled, no issue
    cyc(); drive_id(1, 1, 2, 1, 0, 0, 1);
    @(negedge clk); chk("redir_issue", 32'(issue), 1);
    cyc(); drive_id(1, 1, 0, 0, 6, 1, 0);
    @(negedge clk); chk("flush_flag", 32'(if_flush), 1); chk("flush_if_en", 32'(if_en), 1);
    chk("flush_noissue", 32'(issue), 0); chk("flush_state", 32'(state), 2);
    cyc(); idle();
    @(negedge clk); chk("flush_done", 32'(if_flush), 0); chk("flush_run", 32'(state), 1);
    chk("flush_run_en", 32'(if_en), 1);

    // drain/halt with x3 pending
    cyc(); drive_id(0, 0, 0, 0, 3, 1, 0);
    cyc(); idle(); halt_req = 1;
    @(negedge clk); chk("pre_drain_busy", busy_regs, 32'h8);
    cyc(); drive_id(9, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("drain_state", 32'(state), 3); chk("drain_noissue", 32'(issue), 0);
    chk("drain_if_en", 32'(if_en), 0);
    cyc(); idle(); commit(3);
    @(negedge clk); chk("drain_not_yet", 32'(halted), 0);
    cyc(); idle();
    @(negedge clk); chk("halted", 32'(halted), 1); chk("halt_state", 32'(state), 4);
    cyc(); halt_req = 0;
    @(negedge clk); chk("halt_hold", 32'(state), 4);
    cyc();
    @(negedge clk); chk("resume_run", 32'(state), 1);

    // commit to x0 is harmless; commit to idle x7 is a sticky error
    cyc(); commit(0);
    @(negedge clk); chk("x0_commit_ok", 32'(sb_err), 0);
    cyc(); commit(7);
    cyc(); idle();
    @(negedge clk); chk("err_set", 32'(sb_err), 1);
    cyc(); cyc();
    @(negedge clk); chk("err_sticky", 32'(sb_err), 1);

    // async reset in the middle of FLUSH with x4 pending
    cyc(); drive_id(0, 0, 0, 0, 4, 1, 1);
    cyc(); idle();
    @(negedge clk); chk("pre_rst_flush", 32'(state), 2); chk("pre_rst_busy", busy_regs, 32'h10);
    #2;
    rst_n = 0;
    #1;
    chk("arst_state", 32'(state), 0); chk("arst_flush", 32'(if_flush), 0);
    chk("arst_if_en", 32'(if_en), 0); chk("arst_busy", busy_regs, 0);
    chk("arst_err", 32'(sb_err), 0); chk("arst_issue", 32'(issue), 0);
    cyc();
    rst_n = 1;
    for (int i = 0; i < 4; i++) cyc();
    @(negedge clk); chk("reboot_run", 32'(state), 1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
